serial_addsub: RTL

- Bit-serial add/subtract sequencer for multi-cycle ALU operations.
- Sits directly upstream of the one-bit full-adder cell and drives it one operand bit pair per clock, LSB first.
- Holds the carry in a flop between bits and assembles the result in a shift register.
- Reports carry-out and signed overflow, then pulses done for the control unit.

---
 rtl/serial_addsub.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract sequencer: one operand bit pair per clock, LSB first,
// with carry-out and signed overflow. Optional abort input via SERIAL_ADDSUB_ABORT_EN.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_CIN  = CNT_W'(WIDTH - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             msb_cin_q;
  logic             cout_q;
  logic             overflow_q;
  logic             abort_req;

  // One-bit full-adder cell fed from the operand LSBs and the carry flop.
  logic fa_sum, fa_cout;
  assign fa_sum  = a_sr[0] ^ b_sr[0] ^ carry_q;
  assign fa_cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);

  logic last_bit;
  assign last_bit = (cnt_q == LAST_BIT);

`ifdef SERIAL_ADDSUB_ABORT_EN
  // Result as it stood before the accepted start, restored on abort.
  logic [WIDTH-1:0] result_save;
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort_req)     state_d = IDLE;
        else if (last_bit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, serial add, result assembly, flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      carry_q     <= 1'b0;
      msb_cin_q   <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_ABORT_EN
      result_save <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_ABORT_EN
            result_save <= result_q;
`endif
          end
        end
        RUN: begin
          if (abort_req) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADDSUB_ABORT_EN
            result_q <= result_save;
`endif
          end else begin
            result_q <= {fa_sum, result_q[WIDTH-1:1]};
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            carry_q  <= fa_cout;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == MSB_CIN) msb_cin_q <= fa_cout;
            if (last_bit) begin
              cout_q     <= fa_cout;
              overflow_q <= msb_cin_q ^ fa_cout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule
